mem_arbiter: RTL and testbench



---
 rtl/wires.sv | 28 ++
 rtl/arb_picker.sv | 36 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wires.sv
// Shared types and constants for the memory arbiter.
package wires;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_type;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational grant picker: first requester at or after the pointer (wrapping), or lowest index in fixed mode.
// Zero latency; no backpressure, result is only sampled by the arbiter while idle.
module arb_picker
    import wires::*;
#(
    parameter int NPORTS = 2,
    parameter int IW     = idx_width(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     ptr,
    input  logic              fixed,
    output logic [NPORTS-1:0] grant,
    output logic [IW-1:0]     idx,
    output logic              any
);

    logic [IW-1:0] start;
    logic [IW-1:0] cidx;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cidx  = '0;
        start = fixed ? '0 : ptr;
        for (int k = 0; k < NPORTS; k++) begin
            cidx = IW'((int'(start) + k) % NPORTS);
            if (!any && req[cidx]) begin
                any         = 1'b1;
                grant[cidx] = 1'b1;
                idx         = cidx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-requester memory arbiter: one cycle request-to-mem_valid, zero-cycle mem_ready-to-req_ready, one idle bubble between grants.
// Granted requester holds its request until req_ready; optional timeout completes the transaction with req_error.
module mem_arbiter
    import wires::*;
#(
    parameter int NPORTS   = 2,
    parameter int ARB_MODE = ARB_RR,
    parameter int TIMEOUT  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        req_valid,
    input  logic [NPORTS-1:0]        req_instr,
    input  logic [ADDR_W*NPORTS-1:0] req_addr,
    input  logic [DATA_W*NPORTS-1:0] req_wdata,
    input  logic [STRB_W*NPORTS-1:0] req_wstrb,
    output logic [DATA_W*NPORTS-1:0] req_rdata,
    output logic [NPORTS-1:0]        req_ready,
    output logic [NPORTS-1:0]        req_error,
    output logic                     mem_valid,
    output logic                     mem_instr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [STRB_W-1:0]        mem_wstrb,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ready
);

    localparam int IW = idx_width(NPORTS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    arb_state_type     state, state_nxt;
    logic [IW-1:0]     g, g_nxt;
    logic [NPORTS-1:0] g_oh, g_oh_nxt;
    logic [IW-1:0]     ptr, ptr_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;

    logic [NPORTS-1:0] pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    mem_req_t reqs [NPORTS];
    mem_req_t sel;

    arb_picker #(.NPORTS(NPORTS), .IW(IW)) u_picker (
        .req   (req_valid),
        .ptr   (ptr),
        .fixed (ARB_MODE == ARB_FIXED),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            reqs[i].instr = req_instr[i];
            reqs[i].addr  = req_addr[ADDR_W*i +: ADDR_W];
            reqs[i].wdata = req_wdata[DATA_W*i +: DATA_W];
            reqs[i].wstrb = req_wstrb[STRB_W*i +: STRB_W];
        end
    end

    assign sel = reqs[g];

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        g_oh_nxt  = g_oh;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        req_ready = '0;
        req_error = '0;
        req_rdata = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = BUSY;
                    g_nxt     = pick_idx;
                    g_oh_nxt  = pick_grant;
                    cnt_nxt   = '0;
                    if (ARB_MODE == ARB_RR) begin
                        ptr_nxt = (pick_idx == IW'(NPORTS - 1)) ? '0 : pick_idx + 1'b1;
                    end
                end
            end
            BUSY: begin
                mem_valid = req_valid[g];
                mem_instr = sel.instr;
                mem_addr  = sel.addr;
                mem_wdata = sel.wdata;
                mem_wstrb = sel.wstrb;
                // mem_ready takes precedence over both abandon and timeout expiry
                if (mem_ready) begin
                    req_ready                  = g_oh;
                    req_rdata[DATA_W*g +: DATA_W] = mem_rdata;
                    state_nxt                  = IDLE;
                end else if (!req_valid[g]) begin
                    state_nxt = IDLE;
                end else if (TIMEOUT > 0 && cnt == CNT_LAST) begin
                    req_ready = g_oh;
                    req_error = g_oh;
                    state_nxt = IDLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            g     <= '0;
            g_oh  <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            g_oh  <= g_oh_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Checks a 4-port round-robin arbiter (timeout 8) and a 2-port fixed-priority arbiter (no timeout) against a transaction-level model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   rv  [2];
    logic [3:0]   ri  [2];
    logic [127:0] ra  [2];
    logic [127:0] rwd [2];
    logic [15:0]  rs  [2];
    logic         mr  [2];
    logic [31:0]  md  [2];

    logic [127:0] rr_rdata;
    logic [3:0]   rr_rdy, rr_err, rr_mwstrb;
    logic         rr_mvld, rr_minstr;
    logic [31:0]  rr_maddr, rr_mwdata;
    logic [63:0]  fx_rdata;
    logic [1:0]   fx_rdy, fx_err;
    logic [3:0]   fx_mwstrb;
    logic         fx_mvld, fx_minstr;
    logic [31:0]  fx_maddr, fx_mwdata;

    mem_arbiter #(.NPORTS(4), .ARB_MODE(0), .TIMEOUT(8)) u_rr (
        .clk(clk), .rst(rst),
        .req_valid(rv[0]), .req_instr(ri[0]), .req_addr(ra[0]), .req_wdata(rwd[0]), .req_wstrb(rs[0]),
        .req_rdata(rr_rdata), .req_ready(rr_rdy), .req_error(rr_err),
        .mem_valid(rr_mvld), .mem_instr(rr_minstr), .mem_addr(rr_maddr), .mem_wdata(rr_mwdata),
        .mem_wstrb(rr_mwstrb), .mem_rdata(md[0]), .mem_ready(mr[0])
    );

    mem_arbiter #(.NPORTS(2), .ARB_MODE(1), .TIMEOUT(0)) u_fx (
        .clk(clk), .rst(rst),
        .req_valid(rv[1][1:0]), .req_instr(ri[1][1:0]), .req_addr(ra[1][63:0]), .req_wdata(rwd[1][63:0]),
        .req_wstrb(rs[1][7:0]),
        .req_rdata(fx_rdata), .req_ready(fx_rdy), .req_error(fx_err),
        .mem_valid(fx_mvld), .mem_instr(fx_minstr), .mem_addr(fx_maddr), .mem_wdata(fx_mwdata),
        .mem_wstrb(fx_mwstrb), .mem_rdata(md[1]), .mem_ready(mr[1])
    );

    int NP [2] = '{4, 2};
    int MD [2] = '{0, 1};
    int TO [2] = '{8, 0};

    // Transaction-level model: is a transfer open, who owns it, where the next search starts, how long it has waited.
    int   busy [2];
    int   gnt  [2];
    int   ptr  [2];
    int   wait_cyc [2];
    bit   efin [2];
    logic [3:0] prevrdy [2];
    int   vcnt [2];
    logic [3:0] act_rdy [2];
    logic [3:0] act_err [2];
    logic       act_mvld [2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic get_out(input int d, output logic mvld, output logic minstr, output logic [31:0] maddr,
                           output logic [31:0] mwdata, output logic [3:0] mwstrb, output logic [3:0] rdy,
                           output logic [3:0] err, output logic [127:0] rdata);
        if (d == 0) begin
            mvld = rr_mvld; minstr = rr_minstr; maddr = rr_maddr; mwdata = rr_mwdata; mwstrb = rr_mwstrb;
            rdy = rr_rdy; err = rr_err; rdata = rr_rdata;
        end else begin
            mvld = fx_mvld; minstr = fx_minstr; maddr = fx_maddr; mwdata = fx_mwdata; mwstrb = fx_mwstrb;
            rdy = {2'b00, fx_rdy}; err = {2'b00, fx_err}; rdata = {64'd0, fx_rdata};
        end
    endtask

    task automatic model_out(input int d, output logic mvld, output logic minstr, output logic [31:0] maddr,
                             output logic [31:0] mwdata, output logic [3:0] mwstrb, output logic [3:0] rdy,
                             output logic [3:0] err, output logic [127:0] rdata, output bit fin);
        mvld = 0; minstr = 0; maddr = 0; mwdata = 0; mwstrb = 0; rdy = 0; err = 0; rdata = 0; fin = 0;
        if (busy[d] != 0) begin
            int p;
            p      = gnt[d];
            mvld   = rv[d][p];
            minstr = ri[d][p];
            maddr  = ra[d][32*p +: 32];
            mwdata = rwd[d][32*p +: 32];
            mwstrb = rs[d][4*p +: 4];
            if (mr[d]) begin
                rdy[p] = 1'b1;
                rdata[32*p +: 32] = md[d];
                fin = 1;
            end else if (!rv[d][p]) begin
                fin = 1;
            end else if (TO[d] > 0 && wait_cyc[d] == TO[d] - 1) begin
                rdy[p] = 1'b1;
                err[p] = 1'b1;
                fin = 1;
            end
        end
    endtask

    task automatic model_update(input int d);
        if (rst) begin
            busy[d] = 0; gnt[d] = 0; ptr[d] = 0; wait_cyc[d] = 0;
        end else if (busy[d] == 0) begin
            int s;
            s = (MD[d] == 0) ? ptr[d] : 0;
            for (int k = 0; k < NP[d]; k++) begin
                int i;
                i = (s + k) % NP[d];
                if (busy[d] == 0 && rv[d][i]) begin
                    busy[d] = 1; gnt[d] = i; wait_cyc[d] = 0;
                    if (MD[d] == 0) ptr[d] = (i + 1) % NP[d];
                end
            end
        end else if (efin[d]) begin
            busy[d] = 0;
        end else begin
            wait_cyc[d]++;
        end
    endtask

    function automatic logic exp_mvld_now(input int d);
        return (busy[d] != 0) && rv[d][gnt[d]];
    endfunction

    task automatic step();
        #1;
        for (int d = 0; d < 2; d++) begin
            logic e_mvld, e_minstr, a_mvld, a_minstr;
            logic [31:0] e_maddr, e_mwdata, a_maddr, a_mwdata;
            logic [3:0] e_mwstrb, e_rdy, e_err, a_mwstrb, a_rdy, a_err;
            logic [127:0] e_rdata, a_rdata;
            bit fin;
            model_out(d, e_mvld, e_minstr, e_maddr, e_mwdata, e_mwstrb, e_rdy, e_err, e_rdata, fin);
            get_out(d, a_mvld, a_minstr, a_maddr, a_mwdata, a_mwstrb, a_rdy, a_err, a_rdata);
            chk($sformatf("d%0d_mem_valid", d), a_mvld, e_mvld);
            chk($sformatf("d%0d_mem_instr", d), a_minstr, e_minstr);
            chk($sformatf("d%0d_mem_addr", d), a_maddr, e_maddr);
            chk($sformatf("d%0d_mem_wdata", d), a_mwdata, e_mwdata);
            chk($sformatf("d%0d_mem_wstrb", d), a_mwstrb, e_mwstrb);
            chk($sformatf("d%0d_req_ready", d), a_rdy, e_rdy);
            chk($sformatf("d%0d_req_error", d), a_err, e_err);
            chk($sformatf("d%0d_req_rdata", d), a_rdata, e_rdata);
            efin[d]     = fin;
            prevrdy[d]  = e_rdy;
            act_rdy[d]  = a_rdy;
            act_err[d]  = a_err;
            act_mvld[d] = a_mvld;
            if (e_mvld && !fin) vcnt[d]++;
            else vcnt[d] = 0;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_update(d);
        @(negedge clk);
    endtask

    task automatic rand_fields(input int d, input int p);
        ri[d][p]           = 1'($urandom % 2);
        ra[d][32*p +: 32]  = $urandom;
        rwd[d][32*p +: 32] = $urandom;
        rs[d][4*p +: 4]    = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
    endtask

    // Drive one transaction to completion; memory answers 'delay' cycles after mem_valid rises.
    task automatic serve(input int d, input logic [3:0] want, input bit drop, input int delay,
                         input int exp_port, input bit exp_err, input int exp_cyc, input string tag);
        int ncyc;
        ncyc = 0;
        for (int k = 0; k < 40; k++) begin
            rv[d] = want & (drop ? ~prevrdy[d] : 4'hF);
            md[d] = 32'hDEADBEEF;
            mr[d] = exp_mvld_now(d) && (vcnt[d] >= delay);
            step();
            if (act_mvld[d]) ncyc++;
            if (act_rdy[d] != 4'h0) break;
        end
        chk({tag, "_port"}, act_rdy[d], 128'd1 << exp_port);
        chk({tag, "_err"}, act_err[d], exp_err ? (128'd1 << exp_port) : 128'd0);
        chk({tag, "_cycles"}, ncyc, exp_cyc);
    endtask

    task automatic rand_drive(input int d, input int prob);
        for (int p = 0; p < NP[d]; p++) begin
            if (prevrdy[d][p]) rv[d][p] = 1'b0;
            else if (rv[d][p]) begin
                if ($urandom % 50 == 0) rv[d][p] = 1'b0;
            end else if ($urandom % 3 == 0) begin
                rv[d][p] = 1'b1;
                rand_fields(d, p);
            end
        end
        md[d] = $urandom;
        mr[d] = exp_mvld_now(d) && ($urandom % 100 < prob);
    endtask

    initial begin
        int probs [4] = '{50, 10, 0, 90};
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 0; ri[d] = 0; ra[d] = 0; rwd[d] = 0; rs[d] = 0; mr[d] = 0; md[d] = 0;
            busy[d] = 0; gnt[d] = 0; ptr[d] = 0; wait_cyc[d] = 0; efin[d] = 0;
            prevrdy[d] = 0; vcnt[d] = 0; act_rdy[d] = 0; act_err[d] = 0; act_mvld[d] = 0;
            for (int p = 0; p < NP[d]; p++) rand_fields(d, p);
        end
        @(posedge clk);
        @(negedge clk);
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) step();

        // Round-robin alternation with a two-cycle memory
        serve(0, 4'b0011, 1, 2, 0, 0, 3, "rr_first");
        serve(0, 4'b0011, 1, 2, 1, 0, 3, "rr_second");
        serve(0, 4'b0011, 1, 2, 0, 0, 3, "rr_third");
        serve(0, 4'b0011, 1, 2, 1, 0, 3, "rr_fourth");
        rv[0] = 0; step();

        // Pointer now at 2: port 3 first, then wrap to port 1
        serve(0, 4'b1010, 1, 0, 3, 0, 1, "wrap_first");
        serve(0, 4'b1010, 1, 0, 1, 0, 1, "wrap_second");
        rv[0] = 0; step();

        // Timeout after 8 BUSY cycles, and mem_ready on the 8th cycle beats it
        serve(0, 4'b0100, 1, 99, 2, 1, 8, "timeout");
        rv[0] = 0; step();
        serve(0, 4'b0100, 1, 7, 2, 0, 8, "timeout_edge");
        rv[0] = 0; step();

        // Fixed priority: port 0 keeps requesting and starves port 1
        serve(1, 4'b0011, 0, 0, 0, 0, 1, "fixed_a");
        serve(1, 4'b0011, 0, 0, 0, 0, 1, "fixed_b");
        serve(1, 4'b0011, 0, 0, 0, 0, 1, "fixed_c");
        serve(1, 4'b0010, 1, 0, 1, 0, 1, "fixed_starved");
        rv[1] = 0; step();

        // Reset in the 3rd BUSY cycle
        rv[0] = 4'b0001; mr[0] = 0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0; rv[0] = 0;
        step();
        chk("reset_mem_valid", act_mvld[0], 1'b0);
        serve(0, 4'b0011, 1, 1, 0, 0, 2, "reset_ptr");
        rv[0] = 0; step();

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom % 400 == 0);
            for (int d = 0; d < 2; d++) rand_drive(d, probs[(c / 250) % 4]);
            step();
        end
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 0; mr[d] = 0;
        end
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
